elastic_pipe: RTL and testbench

ELASTIC_PIPE -- requirements
Module: elastic_pipe

---
 rtl/riscv_pkg.sv | 11 +
 rtl/elastic_stage.sv | 85 ++++++++
 rtl/elastic_pipe.sv | 74 +++++++
 tb/tb_elastic_pipe.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the CPU pipeline blocks.
// Holds the occupancy state of an elastic (main + skid) stage.
package riscv_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_t;

endpackage

// File: rtl/elastic_stage.sv
// One elastic pipeline stage: a main register plus a skid register.
// Ready is registered, so upstream never sees a combinational path from downstream.
module elastic_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);
    import riscv_pkg::*;

    stage_state_t     state;
    stage_state_t     next_state;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             push;
    logic             pop;

    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign out_data = main_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // A flush empties both slots; a beat popping out still leaves, a beat pushing in is lost.
    always_comb begin
        next_state = state;
        unique case (state)
            EMPTY: if (push) next_state = ONE;
            ONE: begin
                if (push && !pop) begin
                    next_state = TWO;
                end else if (!push && pop) begin
                    next_state = EMPTY;
                end
            end
            TWO:     if (pop) next_state = ONE;
            default: next_state = EMPTY;
        endcase
        if (flush) begin
            next_state = EMPTY;
        end
    end

    always_comb begin
        in_ready  = (state != TWO);
        out_valid = (state != EMPTY);
        unique case (state)
            ONE:     count = 2'd1;
            TWO:     count = 2'd2;
            default: count = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_data <= '0;
            skid_data <= '0;
        end else begin
            if ((state == EMPTY && push) || (state == ONE && push && pop)) begin
                main_data <= in_data;
            end
            if (state == ONE && push && !pop) begin
                skid_data <= in_data;
            end
            if (state == TWO && pop) begin
                main_data <= skid_data;
            end
        end
    end

endmodule

// File: rtl/elastic_pipe.sv
// Chain of DEPTH elastic stages with per-stage flush and an occupancy count.
// Output side is the main slot of the last stage.
module elastic_pipe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data,
    input  logic [DEPTH-1:0]               flush,
    output logic [DEPTH-1:0]               stage_valid,
    output logic [$clog2(2*DEPTH+1)-1:0]   occupancy
);
    localparam int OCC_W = $clog2(2*DEPTH+1);

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] ready;
    logic [WIDTH-1:0] data  [DEPTH];
    logic [1:0]       count [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;
        logic             down_ready;

        if (i == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = in_data;
        end else begin : g_link
            assign up_valid = valid[i-1];
            assign up_data  = data[i-1];
        end

        if (i == DEPTH - 1) begin : g_tail
            assign down_ready = out_ready;
        end else begin : g_next
            assign down_ready = ready[i+1];
        end

        elastic_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush[i]),
            .in_valid (up_valid),
            .in_ready (ready[i]),
            .in_data  (up_data),
            .out_valid(valid[i]),
            .out_ready(down_ready),
            .out_data (data[i]),
            .count    (count[i])
        );
    end

    assign in_ready    = ready[0];
    assign out_valid   = valid[DEPTH-1];
    assign out_data    = data[DEPTH-1];
    assign stage_valid = valid;

    // Occupancy is the sum of per-stage fill, so flushes and transfers are reflected together.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(count[i]);
        end
    end

endmodule

// File: tb/tb_elastic_pipe.sv
// Directed bench for elastic_pipe (WIDTH=32, DEPTH=3).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_elastic_pipe;

    localparam int WIDTH = 32;
    localparam int DEPTH = 3;
    localparam int OCC_W = $clog2(2*DEPTH+1);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [DEPTH-1:0] flush;
    logic [DEPTH-1:0] stage_valid;
    logic [OCC_W-1:0] occupancy;

    int n_compared   = 0;
    int n_mismatched = 0;

    elastic_pipe #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .flush      (flush),
        .stage_valid(stage_valid),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = '0;
        #2 rst = 1'b0;
        #2;
        n_compared++; if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_compared++; if (out_data !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data); end
        n_compared++; if (stage_valid !== 3'b000) begin n_mismatched++; $display("[TB] FAIL reset_stage_valid: got %b expected 000", stage_valid); end
        n_compared++; if (occupancy !== 3'd0) begin n_mismatched++; $display("[TB] FAIL reset_occupancy: got %0d expected 0", occupancy); end
        n_compared++; if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_streaming();
        $display("[TB] streaming 0x1..0x8");
        out_ready = 1'b1; flush = '0;
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 8);
            in_data  = 32'(c + 1);
            @(negedge clk);
            if (c < 8) begin
                n_compared++; if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL stream_in_ready c=%0d: got %b expected 1", c, in_ready); end
            end
            n_compared++;
            if (out_valid !== ((c >= 3) && (c < 11))) begin
                n_mismatched++; $display("[TB] FAIL stream_out_valid c=%0d: got %b expected %b", c, out_valid, ((c >= 3) && (c < 11)));
            end
            if (c >= 3 && c < 11) begin
                n_compared++; if (out_data !== 32'(c - 2)) begin n_mismatched++; $display("[TB] FAIL stream_out_data c=%0d: got %h expected %h", c, out_data, 32'(c - 2)); end
            end
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_compared++; if (occupancy !== 3'd0) begin n_mismatched++; $display("[TB] FAIL stream_drained_occ: got %0d expected 0", occupancy); end
        tick();
    endtask

    task automatic test_backpressure();
        int accepted = 0;
        int got = 0;
        $display("[TB] backpressure fill and release");
        out_ready = 1'b0; in_valid = 1'b1; flush = '0;
        for (int c = 0; c < 10; c++) begin
            in_data = 32'h20 + 32'(accepted);
            @(negedge clk);
            n_compared++; if (in_ready !== (c < 6)) begin n_mismatched++; $display("[TB] FAIL bp_in_ready c=%0d: got %b expected %b", c, in_ready, (c < 6)); end
            n_compared++; if (occupancy !== OCC_W'((c < 6) ? c : 6)) begin n_mismatched++; $display("[TB] FAIL bp_occupancy c=%0d: got %0d expected %0d", c, occupancy, ((c < 6) ? c : 6)); end
            if (c >= 3) begin
                n_compared++; if (out_valid !== 1'b1 || out_data !== 32'h20) begin n_mismatched++; $display("[TB] FAIL bp_hold c=%0d: got %b/%h expected 1/00000020", c, out_valid, out_data); end
            end
            if (in_ready) accepted++;
            tick();
        end
        in_valid = 1'b0;
        n_compared++; if (accepted != 6) begin n_mismatched++; $display("[TB] FAIL bp_accepted: got %0d expected 6", accepted); end
        n_compared++; if (stage_valid !== 3'b111) begin n_mismatched++; $display("[TB] FAIL bp_stage_valid: got %b expected 111", stage_valid); end
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid) begin
                n_compared++; if (out_data !== 32'h20 + 32'(got)) begin n_mismatched++; $display("[TB] FAIL bp_drain_data #%0d: got %h expected %h", got, out_data, 32'h20 + 32'(got)); end
                got++;
            end
            tick();
        end
        n_compared++; if (got != 6) begin n_mismatched++; $display("[TB] FAIL bp_drain_count: got %0d expected 6", got); end
        n_compared++; if (occupancy !== 3'd0) begin n_mismatched++; $display("[TB] FAIL bp_drain_occ: got %0d expected 0", occupancy); end
    endtask

    task automatic test_flush_mid();
        logic [31:0] exp_seq [7] = '{32'h10, 32'h11, 32'h12, 32'h14, 32'h15, 32'h16, 32'h17};
        int got = 0;
        $display("[TB] mid-stream flush of stage 1");
        out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            in_valid = (c < 8);
            in_data  = 32'h10 + 32'(c);
            flush    = (c == 4) ? 3'b010 : 3'b000;
            @(negedge clk);
            if (c == 5) begin
                n_compared++; if (occupancy !== 3'd2) begin n_mismatched++; $display("[TB] FAIL flush_occupancy: got %0d expected 2", occupancy); end
                n_compared++; if (stage_valid !== 3'b101) begin n_mismatched++; $display("[TB] FAIL flush_stage_valid: got %b expected 101", stage_valid); end
            end
            if (out_valid) begin
                n_compared++;
                if (got >= 7) begin
                    n_mismatched++; $display("[TB] FAIL flush_extra_beat: got %h expected no beat", out_data);
                end else if (out_data !== exp_seq[got]) begin
                    n_mismatched++; $display("[TB] FAIL flush_data #%0d: got %h expected %h", got, out_data, exp_seq[got]);
                end
                got++;
            end
            tick();
        end
        flush = '0; in_valid = 1'b0;
        n_compared++; if (got != 7) begin n_mismatched++; $display("[TB] FAIL flush_count: got %0d expected 7", got); end
        n_compared++; if (occupancy !== 3'd0) begin n_mismatched++; $display("[TB] FAIL flush_final_occ: got %0d expected 0", occupancy); end
    endtask

    task automatic test_flush_push();
        int got = 0;
        $display("[TB] flush stage 0 together with a push");
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'hAA; flush = 3'b001;
        @(negedge clk);
        n_compared++; if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL fp_in_ready: got %b expected 1", in_ready); end
        tick();
        in_data = 32'hBB; flush = 3'b000;
        @(negedge clk);
        n_compared++; if (occupancy !== 3'd0) begin n_mismatched++; $display("[TB] FAIL fp_occupancy: got %0d expected 0", occupancy); end
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) begin
                n_compared++; if (out_data !== 32'hBB) begin n_mismatched++; $display("[TB] FAIL fp_data: got %h expected 000000bb", out_data); end
                got++;
            end
            tick();
        end
        n_compared++; if (got != 1) begin n_mismatched++; $display("[TB] FAIL fp_count: got %0d expected 1", got); end
    endtask

    task automatic test_reset_mid();
        $display("[TB] reset with four beats held");
        out_ready = 1'b0; flush = '0; in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_data = 32'h40 + 32'(c);
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_compared++; if (occupancy !== 3'd4) begin n_mismatched++; $display("[TB] FAIL rm_pre_occ: got %0d expected 4", occupancy); end
        #1 rst = 1'b0;
        #1;
        n_compared++; if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rm_out_valid: got %b expected 0", out_valid); end
        n_compared++; if (occupancy !== 3'd0) begin n_mismatched++; $display("[TB] FAIL rm_occupancy: got %0d expected 0", occupancy); end
        n_compared++; if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rm_in_ready: got %b expected 1", in_ready); end
        n_compared++; if (out_data !== 32'h0) begin n_mismatched++; $display("[TB] FAIL rm_out_data: got %h expected 0", out_data); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_valid = (c == 0);
            in_data  = 32'h55;
            @(negedge clk);
            n_compared++; if (out_valid !== (c == 3)) begin n_mismatched++; $display("[TB] FAIL rm_lat_valid c=%0d: got %b expected %b", c, out_valid, (c == 3)); end
            if (c == 3) begin
                n_compared++; if (out_data !== 32'h55) begin n_mismatched++; $display("[TB] FAIL rm_lat_data: got %h expected 00000055", out_data); end
            end
            tick();
        end
    endtask

    task automatic test_random_stall();
        logic [31:0] sb [$];
        logic [31:0] next_data = 32'h1000;
        logic [31:0] prev_data = '0;
        logic [31:0] want;
        logic        prev_stall = 1'b0;
        int          received = 0;
        int          cycles = 0;
        $display("[TB] random stall, 1000 beats");
        flush = '0;
        while (received < 1000 && cycles < 6000) begin
            in_valid  = ($urandom_range(0, 9) < 8);
            in_data   = next_data;
            out_ready = ($urandom_range(0, 9) >= 3);
            @(negedge clk);
            if (prev_stall) begin
                n_compared++; if (out_valid !== 1'b1 || out_data !== prev_data) begin n_mismatched++; $display("[TB] FAIL rs_stable cyc=%0d: got %b/%h expected 1/%h", cycles, out_valid, out_data, prev_data); end
            end
            if (in_valid && in_ready) begin
                sb.push_back(in_data);
                next_data++;
            end
            if (out_valid && out_ready) begin
                n_compared++;
                if (sb.size() == 0) begin
                    n_mismatched++; $display("[TB] FAIL rs_unexpected: got %h expected no beat", out_data);
                end else begin
                    want = sb.pop_front();
                    if (out_data !== want) begin n_mismatched++; $display("[TB] FAIL rs_data #%0d: got %h expected %h", received, out_data, want); end
                end
                received++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            tick();
            cycles++;
        end
        n_compared++; if (received != 1000) begin n_mismatched++; $display("[TB] FAIL rs_timeout: got %0d beats expected 1000", received); end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) begin
                n_compared++;
                if (sb.size() == 0) begin
                    n_mismatched++; $display("[TB] FAIL rs_drain_extra: got %h expected no beat", out_data);
                end else begin
                    want = sb.pop_front();
                    if (out_data !== want) begin n_mismatched++; $display("[TB] FAIL rs_drain_data: got %h expected %h", out_data, want); end
                end
            end
            tick();
        end
        n_compared++; if (sb.size() != 0) begin n_mismatched++; $display("[TB] FAIL rs_left: got %0d beats left expected 0", sb.size()); end
        n_compared++; if (occupancy !== 3'd0) begin n_mismatched++; $display("[TB] FAIL rs_final_occ: got %0d expected 0", occupancy); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_mid();
        test_flush_push();
        test_reset_mid();
        test_random_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
